tff_sync_counter: RTL

Parametrised synchronous up/down counter built on T-flip-flop toggle semantics. It generalises the single-bit toggle cell into a WIDTH-bit counter with programmable modulus, direction, parallel load, synchronous clear, saturate/wrap mode and cascade outputs. It is the counting core for the synchronous-counter designs. It can be chained, with tc of one stage driving en of the next.

---
 rtl/tff_sync_counter.sv | 112 +++++++++++
 1 files changed

// File: rtl/tff_sync_counter.sv
// Modulo-MODULUS synchronous up/down counter built on T-flip-flop toggle enables.
// It supports parallel load, synchronous clear, wrap or saturate mode and a cascade terminal count.
module tff_sync_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int unsigned     SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [WIDTH-1:0] toggle,
  output logic             wrap,
  output logic             load_err
);

  localparam longint unsigned MOD_LIMIT = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MODULUS - 64'd1);
  localparam bit               SAT      = (SATURATE != 0);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("tff_sync_counter: WIDTH must be within 1..32");
  end
  if (MODULUS < 2 || MODULUS > MOD_LIMIT) begin : g_bad_modulus
    $error("tff_sync_counter: MODULUS must be within 2..2**WIDTH");
  end

  logic             at_max;
  logic             at_zero;
  logic             at_limit;
  logic             out_of_range;
  logic             din_ok;
  logic             cnt_cmd;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             load_err_nxt;
  logic [WIDTH-1:0] classic;
  logic             run_up;
  logic             run_dn;

  assign at_max       = (q == MAX_Q);
  assign at_zero      = (q == '0);
  assign at_limit     = up ? at_max : at_zero;
  assign out_of_range = (64'(q) >= MODULUS);
  assign din_ok       = (64'(din) < MODULUS);
  assign cnt_cmd      = en & ~clr & ~load;

  assign tc = cnt_cmd & at_limit;

  // Next count: clr beats load, load beats en; an unused state always recovers to 0.
  always_comb begin
    q_nxt        = q;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      if (din_ok) begin
        q_nxt = din;
      end else begin
        q_nxt        = MAX_Q;
        load_err_nxt = 1'b1;
      end
    end else if (en) begin
      if (out_of_range) begin
        q_nxt = '0;
      end else if (at_limit) begin
        if (!SAT) begin
          q_nxt    = up ? '0 : MAX_Q;
          wrap_nxt = 1'b1;
        end
      end else begin
        q_nxt = up ? q + WIDTH'(1) : q - WIDTH'(1);
      end
    end
  end

  // Ripple-free T-flip-flop enables: bit i flips when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    classic = '0;
    run_up  = 1'b1;
    run_dn  = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      classic[i] = up ? run_up : run_dn;
      run_up     = run_up & q[i];
      run_dn     = run_dn & ~q[i];
    end
  end

  // The classic equation is wrong only at the wrap point (and in unused states); take the real delta there.
  assign toggle = !cnt_cmd                   ? '0 :
                  (at_limit || out_of_range) ? (q ^ q_nxt) :
                                               classic;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule
